// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART receive path:
//   - rx_state_t : receiver FSM state encoding
//   - PAR_*      : parity mode constants for the PARITY_MODE parameter
//   - majority3  : 2-of-3 vote used when UART_RX_MAJORITY_EN is defined
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Line synchroniser, bit-period counter and sample-point generator for the
// UART receiver. The counter is held clear while cnt_clr is high; the first
// period after release is half a bit (lands mid start bit), every later one
// is a full bit, so the FSM only needs to react to sample_stb.
//
// Optional feature, macro UART_RX_MAJORITY_EN:
//   defined   - each sample is the 2-of-3 majority of rx_s at the nominal
//               point and one clock either side; the strobe is one clock late
//   undefined - single sample of rx_s at the nominal point
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   rx         in   raw asynchronous serial line (idle high)
//   cnt_clr    in   hold counter at start of a half-bit period
//   rx_s       out  synchronised line
//   sample_stb out  one-cycle strobe, sample_bit valid with it
//   sample_bit out  sampled line value
// ---------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic cnt_clr,
  output logic rx_s,
  output logic sample_stb,
  output logic sample_bit
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);

  logic          sync1;
  logic          rx_q;
  logic [CW-1:0] cnt;
  logic          first;
  logic          hit;

  assign rx_s = rx_q;
  assign hit  = (cnt == (first ? HALF_T : FULL_T));

  // Two-flop synchroniser, reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_q  <= sync1;
    end
  end

  // Bit-period counter: wraps on every sample point, half period first
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (hit) begin
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_d1;
  logic rx_d2;
  logic pend;

  // Vote is taken one clock after the nominal point so the +1 sample exists
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_d1      <= 1'b1;
      rx_d2      <= 1'b1;
      pend       <= 1'b0;
      sample_stb <= 1'b0;
      sample_bit <= 1'b1;
    end else begin
      rx_d1      <= rx_q;
      rx_d2      <= rx_d1;
      pend       <= hit && !cnt_clr;
      sample_stb <= pend && !cnt_clr;
      if (pend) begin
        sample_bit <= majority3(rx_d2, rx_d1, rx_q);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_stb <= 1'b0;
      sample_bit <= 1'b1;
    end else begin
      sample_stb <= hit && !cnt_clr;
      if (hit) begin
        sample_bit <= rx_q;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver with valid/ready output, parity/framing/overrun
// flags, false-start rejection and break handling. Sampling timing lives in
// uart_rx_sampler; this file holds the frame FSM and the output register.
// Optional majority sampling is selected by macro UART_RX_MAJORITY_EN.
//
// Ports:
//   i_clk        in   system clock, rising edge
//   i_reset      in   synchronous active-high reset
//   i_rx         in   asynchronous serial line, idle high
//   i_rxready    in   consumer accepts the presented word
//   o_rxdata     out  received word, first serial bit in bit 0
//   o_rxvalid    out  word available, held until accepted
//   o_parity_err out  parity mismatch for presented word
//   o_frame_err  out  a stop-bit sample was 0 for presented word
//   o_overrun    out  presented word overwrote an unaccepted one
//   o_busy       out  receiver not idle
// ---------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_rxready,
  output logic [DATA_BITS-1:0] o_rxdata,
  output logic                 o_rxvalid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  rx_state_t            state;
  logic                 rx_s;
  logic                 sample_stb;
  logic                 sample_bit;
  logic                 cnt_clr;
  logic                 armed;
  logic                 par_acc;
  logic                 perr;
  logic                 ferr;
  logic                 stop_cnt;
  logic                 frame_bad;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

  // Counter sits at the start of a half-bit period until a start edge
  assign cnt_clr   = (state == IDLE);
  assign frame_bad = ferr | ~sample_bit;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk       (i_clk),
    .reset     (i_reset),
    .rx        (i_rx),
    .cnt_clr   (cnt_clr),
    .rx_s      (rx_s),
    .sample_stb(sample_stb),
    .sample_bit(sample_bit)
  );

  // armed blocks a new start until the line has been seen high, so a held
  // low line (break, or reset released mid-low) cannot retrigger frames.
  // The acceptance clear is placed before the FSM so a completion in the
  // same cycle overrides it and keeps o_rxvalid high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      armed        <= 1'b0;
      par_acc      <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      stop_cnt     <= 1'b0;
      bit_idx      <= '0;
      shreg        <= '0;
      o_rxdata     <= '0;
      o_rxvalid    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      if (o_rxvalid && i_rxready) begin
        o_rxvalid <= 1'b0;
        o_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end
          if (armed && !rx_s) begin
            state  <= START;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (sample_stb) begin
            if (sample_bit) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
              par_acc <= 1'b0;
              perr    <= 1'b0;
            end
          end
        end

        DATA: begin
          if (sample_stb) begin
            shreg   <= {sample_bit, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ sample_bit;
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              stop_cnt <= 1'b0;
              ferr     <= 1'b0;
              state    <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          // Even: total XOR must be 0; odd: total XOR must be 1
          if (sample_stb) begin
            perr  <= par_acc ^ sample_bit ^ (PARITY_MODE == PAR_ODD);
            state <= STOP;
          end
        end

        STOP: begin
          if (sample_stb) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              o_rxdata     <= shreg;
              o_rxvalid    <= 1'b1;
              o_parity_err <= perr;
              o_frame_err  <= frame_bad;
              o_overrun    <= o_rxvalid & ~i_rxready;
              if (frame_bad) begin
                armed <= 1'b0;
              end
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
              ferr     <= frame_bad;
            end
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, the successor to the fixed 8N1 receive path inside the UART top.
- Data width, parity mode, stop-bit count and bit period are all configurable.
- Adds valid/ready output handshake, parity/framing/overrun flags, false-start rejection and break handling.
- Sits between the serial line pin and the consumer logic; pairs with the existing transmitter in loopback tops.

Parameters:
- CLKS_PER_BIT, 10, i_clk cycles per serial bit; legal range >= 4.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line, idle high.
- i_rxready  input  1  consumer accepts o_rxdata when high with o_rxvalid.
- o_rxdata  output  DATA_BITS  received word; first serial bit is bit 0.
- o_rxvalid  output  1  word available; held until accepted.
- o_parity_err  output  1  parity mismatch for the presented word (always 0 when PARITY_MODE=0).
- o_frame_err  output  1  a stop-bit sample was 0 for the presented word.
- o_overrun  output  1  the presented word overwrote an unaccepted one.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - o_rxdata = 0; o_rxvalid, o_parity_err, o_frame_err, o_overrun, o_busy = 0.
  - Synchroniser flops = 1; state = IDLE; armed = 0.
- i_rx passes through a 2-flop synchroniser; all decisions use the synchronised line rx_s.
- armed flag:
  - Set when rx_s is seen high in IDLE.
  - Cleared on reset and on every frame completion that had a frame error.
  - A start bit is only accepted when armed = 1. Continuous low therefore never retriggers (break, or reset released mid-low).
- FSM:
  - IDLE: armed and rx_s = 0 -> START, counter = 0.
  - START: at counter = CLKS_PER_BIT/2 - 1, sample rx_s. If high -> IDLE (false start, no output). If low -> DATA, counter = 0, bit index = 0.
  - DATA: sample at counter = CLKS_PER_BIT - 1, shift in LSB-first and reset the counter. After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: sample after CLKS_PER_BIT clocks. Error if XOR(data, parity bit) != 0 for even, or != 1 for odd.
  - STOP: STOP_BITS samples, each CLKS_PER_BIT apart. Any 0 sets the frame error. After the last sample, load outputs and go directly to IDLE (mid-stop-bit), so back-to-back frames are received.
- Latency: o_rxvalid rises exactly 3 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT clocks after the first clock edge that sees i_rx low. P = 0 or 1 for parity. Default value: 98.
- Handshake and output load:
  - o_rxvalid drops the cycle after i_rxvalid && i_rxready.
  - The completion cycle loads o_rxdata and all flags together.
  - Completion while valid is pending without ready: overwrite, o_overrun = 1.
  - Completion in the same cycle as acceptance: new word loaded, o_rxvalid stays 1, o_overrun = 0.
  - Flags stay stable while o_rxvalid = 1. o_overrun clears on acceptance.
- Break (all-zero frame): delivered with data 0 and o_frame_err = 1. No new start is accepted until rx_s has returned high.
- i_reset mid-frame: abort the frame and drop any pending word; reset values apply on the next cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample point takes rx_s at offsets -1, 0 and +1 around the nominal point and uses the 2-of-3 majority. The decision lands one clock later, so total latency is +1 (99 at defaults).
- Undefined: a single sample at the nominal point, latency as stated above.

Decomposition:
- uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP); parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
- Sub-module uart_rx_sampler: synchroniser, bit-period counter and (optional) majority voter. It outputs a one-cycle sample strobe plus the sampled bit. The FSM lives in uart_rx_param.

Test Plan:
- Default parameters, i_rxready = 1, drive 8'hB5 as 8N1 at 10 clocks/bit -> o_rxvalid pulses 1 cycle at edge 98, o_rxdata = 8'hB5, all flags 0.
- PARITY_MODE = 1, send 8'hA9 with parity bit 1 (wrong) -> o_rxdata = 8'hA9, o_parity_err = 1. Resend with parity 0 -> o_parity_err = 0.
- i_rxready = 0, send 8'hF0 then 8'h33 back-to-back -> after frame 2 o_rxdata = 8'h33, o_overrun = 1. Raise i_rxready one cycle -> o_rxvalid = 0, o_overrun = 0.
- 3-clock low glitch on i_rx -> no o_rxvalid, o_busy returns 0 within 8 cycles. A following valid frame 8'h5A is received correctly.
- Hold i_rx low for 30 bit times -> one word 8'h00 with o_frame_err = 1, no further words. Release high and send 8'h01 -> received cleanly.
- Assert i_reset at DATA bit 4 of a frame -> all outputs 0 next cycle, no word delivered. Send 8'hC3 afterwards -> received correctly.
